// File: rtl/mem_tile_net_endpoint.sv
// Memory-tile network endpoint: reassembles request flits, issues one storage
// access per request and serializes the response back onto the mesh.
package mem_tile_net_endpoint_pkg;
    localparam int unsigned FLIT_ADDR_W = 32;
    localparam int unsigned FLIT_DATA_W = 64;
    localparam int unsigned XFER_TYPE_W = 2;
    localparam int unsigned PSIZE_W     = 6;
    localparam int unsigned PRIO_W      = 2;
    localparam int unsigned SRC_CORE_W  = 5;

    typedef struct packed {
        logic [FLIT_ADDR_W-1:0] addr;
        logic                   is_read;
        logic                   is_wide;
        logic [XFER_TYPE_W-1:0] transfer_type;
        logic [PSIZE_W-1:0]     payload_size;
        logic [PRIO_W-1:0]      ipriority;
        logic [SRC_CORE_W-1:0]  src_core;
        logic                   last_flit;
        logic [FLIT_DATA_W-1:0] data;
    } generic_flit_t;
endpackage

module mem_tile_net_endpoint
    import mem_tile_net_endpoint_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned FLIT_SIZE  = 64,
    parameter int unsigned WIDE_WIDTH = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  generic_flit_t                     rx_flit,
    input  logic                              rx_req,
    output logic                              rx_ack,
    output generic_flit_t                     tx_flit,
    output logic                              tx_req,
    input  logic                              tx_ack,
    output logic                              mem_req,
    output logic                              mem_we,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [WIDE_WIDTH-1:0]             mem_wdata,
    output logic [WIDE_WIDTH/FLIT_SIZE-1:0]   mem_wmask,
    input  logic                              mem_ready,
    input  logic                              mem_rvalid,
    input  logic [WIDE_WIDTH-1:0]             mem_rdata,
    output logic                              proto_err,
    output logic [15:0]                       req_count
);

    localparam int unsigned BEATS    = WIDE_WIDTH / FLIT_SIZE;
    localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned LANE_LSB = $clog2(FLIT_SIZE / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    armed_q;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [FLIT_ADDR_W-1:0]  hdr_addr_q, hdr_addr_d;
    logic                    hdr_read_q, hdr_read_d;
    logic                    hdr_wide_q, hdr_wide_d;
    logic [PRIO_W-1:0]       hdr_prio_q, hdr_prio_d;
    logic [SRC_CORE_W-1:0]   hdr_src_q, hdr_src_d;
    logic [WIDE_WIDTH-1:0]   rbuf_q, rbuf_d;

    generic_flit_t           tx_flit_d;
    logic                    tx_req_d;
    logic                    mem_req_d;
    logic                    mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_d;
    logic [WIDE_WIDTH-1:0]   mem_wdata_d;
    logic [BEATS-1:0]        mem_wmask_d;
    logic                    proto_err_d;
    logic [15:0]             req_count_d;

    logic                    rx_xfer;
    logic [BEAT_W-1:0]       rx_lane;
    logic [BEAT_W-1:0]       hdr_lane;
    logic                    rx_wide_wr;
    logic                    resp_wide;
    generic_flit_t           resp_base;
    logic                    unused_fields;

    assign unused_fields = ^{rx_flit.transfer_type, rx_flit.payload_size};

    // armed_q keeps rx_ack low while reset is held and for the release cycle
    assign rx_ack     = armed_q && (state_q == S_IDLE || state_q == S_COLLECT);
    assign rx_xfer    = rx_req && rx_ack;
    assign rx_lane    = rx_flit.addr[LANE_LSB +: BEAT_W];
    assign hdr_lane   = hdr_addr_q[LANE_LSB +: BEAT_W];
    assign rx_wide_wr = rx_flit.is_wide && !rx_flit.is_read;
    assign resp_wide  = hdr_wide_q && hdr_read_q;

    function automatic logic [FLIT_SIZE-1:0] lane_sel(input logic [WIDE_WIDTH-1:0] v,
                                                      input logic [BEAT_W-1:0]     idx);
        logic [FLIT_SIZE-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (idx == BEAT_W'(i)) r = v[i*FLIT_SIZE +: FLIT_SIZE];
        end
        return r;
    endfunction

    // Response header fields common to every beat of the current request
    always_comb begin
        resp_base               = '0;
        resp_base.addr          = hdr_addr_q;
        resp_base.is_read       = 1'b0;
        resp_base.is_wide       = resp_wide;
        resp_base.transfer_type = '0;
        resp_base.payload_size  = hdr_wide_q ? PSIZE_W'(WIDE_WIDTH / 8) : PSIZE_W'(FLIT_SIZE / 8);
        resp_base.ipriority     = hdr_prio_q;
        resp_base.src_core      = hdr_src_q;
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        hdr_addr_d  = hdr_addr_q;
        hdr_read_d  = hdr_read_q;
        hdr_wide_d  = hdr_wide_q;
        hdr_prio_d  = hdr_prio_q;
        hdr_src_d   = hdr_src_q;
        rbuf_d      = rbuf_q;
        tx_flit_d   = tx_flit;
        tx_req_d    = tx_req;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        mem_wmask_d = mem_wmask;
        proto_err_d = 1'b0;
        req_count_d = req_count;

        case (state_q)
            S_IDLE: begin
                if (rx_xfer) begin
                    hdr_addr_d  = rx_flit.addr;
                    hdr_read_d  = rx_flit.is_read;
                    hdr_wide_d  = rx_flit.is_wide;
                    hdr_prio_d  = rx_flit.ipriority;
                    hdr_src_d   = rx_flit.src_core;
                    mem_addr_d  = ADDR_WIDTH'(rx_flit.addr);
                    mem_we_d    = !rx_flit.is_read;
                    mem_wdata_d = '0;
                    mem_wmask_d = '0;
                    if (rx_wide_wr) begin
                        mem_wdata_d[0 +: FLIT_SIZE] = FLIT_SIZE'(rx_flit.data);
                        mem_wmask_d = '1;
                        proto_err_d = rx_flit.last_flit;
                        beat_d      = BEAT_W'(1);
                        state_d     = S_COLLECT;
                    end else begin
                        if (!rx_flit.is_read) begin
                            for (int unsigned i = 0; i < BEATS; i++) begin
                                if (rx_lane == BEAT_W'(i))
                                    mem_wdata_d[i*FLIT_SIZE +: FLIT_SIZE] = FLIT_SIZE'(rx_flit.data);
                            end
                            mem_wmask_d = BEATS'(1) << rx_lane;
                        end
                        proto_err_d = !rx_flit.last_flit;
                        mem_req_d   = 1'b1;
                        state_d     = S_ISSUE;
                    end
                end
            end

            S_COLLECT: begin
                if (rx_xfer) begin
                    for (int unsigned i = 0; i < BEATS; i++) begin
                        if (beat_q == BEAT_W'(i))
                            mem_wdata_d[i*FLIT_SIZE +: FLIT_SIZE] = FLIT_SIZE'(rx_flit.data);
                    end
                    proto_err_d = rx_flit.last_flit != (beat_q == LAST_BEAT);
                    if (beat_q == LAST_BEAT) begin
                        beat_d    = '0;
                        mem_req_d = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end

            S_ISSUE: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we) begin
                        tx_flit_d           = resp_base;
                        tx_flit_d.last_flit = 1'b1;
                        tx_flit_d.data      = '0;
                        tx_req_d            = 1'b1;
                        beat_d              = '0;
                        state_d             = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                // First beat comes straight from mem_rdata; later beats from rbuf
                if (mem_rvalid) begin
                    rbuf_d              = mem_rdata;
                    tx_flit_d           = resp_base;
                    tx_flit_d.last_flit = !resp_wide;
                    tx_flit_d.data      = resp_wide ? FLIT_DATA_W'(lane_sel(mem_rdata, '0))
                                                    : FLIT_DATA_W'(lane_sel(mem_rdata, hdr_lane));
                    tx_req_d            = 1'b1;
                    beat_d              = '0;
                    state_d             = S_RESP;
                end
            end

            S_RESP: begin
                if (tx_ack) begin
                    if (!resp_wide || beat_q == LAST_BEAT) begin
                        tx_req_d    = 1'b0;
                        beat_d      = '0;
                        req_count_d = req_count + 16'd1;
                        state_d     = S_IDLE;
                    end else begin
                        beat_d              = beat_q + BEAT_W'(1);
                        tx_flit_d.data      = FLIT_DATA_W'(lane_sel(rbuf_q, beat_q + BEAT_W'(1)));
                        tx_flit_d.last_flit = (beat_q + BEAT_W'(1)) == LAST_BEAT;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            armed_q    <= 1'b0;
            beat_q     <= '0;
            hdr_addr_q <= '0;
            hdr_read_q <= 1'b0;
            hdr_wide_q <= 1'b0;
            hdr_prio_q <= '0;
            hdr_src_q  <= '0;
            rbuf_q     <= '0;
            tx_flit    <= '0;
            tx_req     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            proto_err  <= 1'b0;
            req_count  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= 1'b1;
            beat_q     <= beat_d;
            hdr_addr_q <= hdr_addr_d;
            hdr_read_q <= hdr_read_d;
            hdr_wide_q <= hdr_wide_d;
            hdr_prio_q <= hdr_prio_d;
            hdr_src_q  <= hdr_src_d;
            rbuf_q     <= rbuf_d;
            tx_flit    <= tx_flit_d;
            tx_req     <= tx_req_d;
            mem_req    <= mem_req_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            mem_wmask  <= mem_wmask_d;
            proto_err  <= proto_err_d;
            req_count  <= req_count_d;
        end
    end

endmodule
